// File: rtl/result_drain.sv
// result_drain: consumer end of the multiplier's result FIFO.
// Pops N*M dot-product results in row-major order, saturates each to OUT_WIDTH,
// and writes them through a valid/ready port at address row*M+col.
//
// Ports:
//   clk_i, rst_i       clock (rising edge), asynchronous active-high reset
//   start_i            begin a drain pass (only honoured in IDLE or DONE)
//   fifo_empty_i       result FIFO empty
//   fifo_head_i        show-ahead FIFO head, valid whenever fifo_empty_i=0
//   pop_fifo_o         combinational pop strobe, removes head at this edge
//   wr_valid_o/wr_ready_i   write handshake
//   wr_addr_o, wr_row_o, wr_col_o, wr_data_o   held output entry
//   busy_o             high while draining
//   done_o             high after last write accepted, until next start
//   sat_count_o        saturated results this pass, sticks at all-ones
module result_drain #(
    parameter int unsigned N           = 8,
    parameter int unsigned M           = 10,
    parameter int unsigned ACCUM_WIDTH = 33,
    parameter int unsigned OUT_WIDTH   = 32,
    parameter int unsigned CNT_WIDTH   = 8,
    localparam int unsigned ADDR_WIDTH = (N * M > 1) ? $clog2(N * M) : 1,
    localparam int unsigned ROW_WIDTH  = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned COL_WIDTH  = (M > 1) ? $clog2(M) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   fifo_empty_i,
    input  logic [ACCUM_WIDTH-1:0] fifo_head_i,
    output logic                   pop_fifo_o,
    output logic                   wr_valid_o,
    input  logic                   wr_ready_i,
    output logic [ADDR_WIDTH-1:0]  wr_addr_o,
    output logic [OUT_WIDTH-1:0]   wr_data_o,
    output logic [ROW_WIDTH-1:0]   wr_row_o,
    output logic [COL_WIDTH-1:0]   wr_col_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [CNT_WIDTH-1:0]   sat_count_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned TOTAL     = N * M;
    // One extra bit of headroom so the pop index can reach TOTAL itself.
    localparam int unsigned IDX_WIDTH = $clog2(TOTAL + 1);

    logic [1:0]            state_q, state_d;
    logic [IDX_WIDTH-1:0]  pop_idx_q;
    logic [ROW_WIDTH-1:0]  pop_row_q;
    logic [COL_WIDTH-1:0]  pop_col_q;
    logic                  wr_valid_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [OUT_WIDTH-1:0]  wr_data_q;
    logic [ROW_WIDTH-1:0]  wr_row_q;
    logic [COL_WIDTH-1:0]  wr_col_q;
    logic                  done_q;
    logic [CNT_WIDTH-1:0]  sat_cnt_q;

    logic [OUT_WIDTH-1:0]  sat_data;
    logic                  sat_hit;
    logic                  pop;
    logic                  accept;
    logic                  last_accept;
    logic                  start_go;

    // Saturation: a narrower output clips when the bits above the output sign bit
    // are not all copies of it; otherwise the value is plainly sign-extended.
    if (OUT_WIDTH >= ACCUM_WIDTH) begin : g_ext
        assign sat_data = OUT_WIDTH'($signed(fifo_head_i));
        assign sat_hit  = 1'b0;
    end else begin : g_sat
        logic [ACCUM_WIDTH-OUT_WIDTH:0] top;
        logic                           in_range;
        assign top      = fifo_head_i[ACCUM_WIDTH-1:OUT_WIDTH-1];
        assign in_range = (&top) | ~(|top);
        assign sat_hit  = ~in_range;
        always_comb begin
            sat_data = fifo_head_i[OUT_WIDTH-1:0];
            if (!in_range) begin
                sat_data = fifo_head_i[ACCUM_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                                      : {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end
        end
    end

    assign start_go    = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign accept      = wr_valid_q && wr_ready_i;
    assign last_accept = accept && (wr_addr_q == ADDR_WIDTH'(TOTAL - 1));
    assign pop         = (state_q == ST_RUN) && !fifo_empty_i &&
                         (pop_idx_q < IDX_WIDTH'(TOTAL)) && (!wr_valid_q || wr_ready_i);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN:  if (last_accept) state_d = ST_DONE;
            ST_DONE: if (start_i) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            pop_idx_q  <= '0;
            pop_row_q  <= '0;
            pop_col_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_row_q   <= '0;
            wr_col_q   <= '0;
            done_q     <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start_go) begin
                pop_idx_q <= '0;
                pop_row_q <= '0;
                pop_col_q <= '0;
                sat_cnt_q <= '0;
                done_q    <= 1'b0;
            end
            if (last_accept) begin
                done_q <= 1'b1;
            end
            // A pop reloads the single output register; this also covers the
            // accept-and-pop case, so wr_valid stays high with no bubble.
            if (pop) begin
                wr_valid_q <= 1'b1;
                wr_data_q  <= sat_data;
                wr_addr_q  <= ADDR_WIDTH'(pop_idx_q);
                wr_row_q   <= pop_row_q;
                wr_col_q   <= pop_col_q;
                pop_idx_q  <= pop_idx_q + 1'b1;
                if (pop_col_q == COL_WIDTH'(M - 1)) begin
                    pop_col_q <= '0;
                    pop_row_q <= pop_row_q + 1'b1;
                end else begin
                    pop_col_q <= pop_col_q + 1'b1;
                end
                if (sat_hit && !(&sat_cnt_q)) begin
                    sat_cnt_q <= sat_cnt_q + 1'b1;
                end
            end else if (accept) begin
                wr_valid_q <= 1'b0;
            end
        end
    end

    assign pop_fifo_o  = pop;
    assign wr_valid_o  = wr_valid_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign wr_row_o    = wr_row_q;
    assign wr_col_o    = wr_col_q;
    assign busy_o      = (state_q == ST_RUN);
    assign done_o      = done_q;
    assign sat_count_o = sat_cnt_q;

endmodule
